// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the multi-domain reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ASSERT,
      HOLD,
      RELEASE,
      DONE
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-reset handshake and per-domain reset outputs of the reset sequencer.
// Latency: n/a (wires only).
// Backpressure: 4-phase req/ack; req must stay high until ack, ack drops after req drops.
// Ports: soft_reset_req/soft_reset_mask (requester -> sequencer),
//        soft_reset_ack, reset_sync, reset_done (sequencer -> requester/domains).
interface reset_sequencer_if #(
   parameter int NUM_DOMAINS = 4
);
   logic                   soft_reset_req;
   logic [NUM_DOMAINS-1:0] soft_reset_mask;
   logic                   soft_reset_ack;
   logic [NUM_DOMAINS-1:0] reset_sync;
   logic                   reset_done;

   modport master (
      output soft_reset_req,
      output soft_reset_mask,
      input  soft_reset_ack,
      input  reset_sync,
      input  reset_done
   );

   modport slave (
      input  soft_reset_req,
      input  soft_reset_mask,
      output soft_reset_ack,
      output reset_sync,
      output reset_done
   );
endinterface

// File: rtl/reset_sync_chain.sv
// Reset deassertion synchronizer: async clear, shifts in 1 to release synchronously.
// Latency: rst_ok rises SYNC_STAGES edges after reset_async_n rises; falls immediately.
// Backpressure: none.
// Ports: sync_clk, reset_async_n (in), rst_ok (out, last stage).
module reset_sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sync_clk,
   input  logic reset_async_n,
   output logic rst_ok
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge sync_clk or negedge reset_async_n) begin
      if (!reset_async_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_ok = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset generator: async assert, sync staggered release, soft re-reset of a mask.
// Latency: domain k released SYNC_STAGES+NUM_EXTEND_CYCLES+1+k*(STAGGER_CYCLES+1) edges after board reset.
// Backpressure: soft requests accepted only when idle with ack low; ignored (not queued) otherwise.
// Ports: sync_clk, reset_async_n (plain); sr (slave modport: req/mask in, ack/reset_sync/reset_done out).
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_DOMAINS       = 4,
   parameter int SYNC_STAGES       = 2,
   parameter int NUM_EXTEND_CYCLES = 4,
   parameter int STAGGER_CYCLES    = 2
) (
   input  logic             sync_clk,
   input  logic             reset_async_n,
   reset_sequencer_if.slave sr
);

   localparam int CNT_MAX = (NUM_EXTEND_CYCLES > STAGGER_CYCLES + 1) ?
                            NUM_EXTEND_CYCLES : STAGGER_CYCLES + 1;
   localparam int CNT_W   = clog2_min1(CNT_MAX) + 1;
   localparam int IDX_W   = clog2_min1(NUM_DOMAINS);

   localparam logic [CNT_W-1:0] EXTEND_LOAD  = CNT_W'(NUM_EXTEND_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

   logic                   rst_ok;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] mask_q, mask_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic                   done_q, done_d;
   logic                   ack_q, ack_d;
   logic                   soft_q, soft_d;   // current sequence was started by a soft request

   reset_sync_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .sync_clk      (sync_clk),
      .reset_async_n (reset_async_n),
      .rst_ok        (rst_ok)
   );

   always_ff @(posedge sync_clk or negedge reset_async_n) begin
      if (!reset_async_n) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
         soft_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         ack_q   <= ack_d;
         soft_q  <= soft_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      rst_d   = rst_q;
      done_d  = done_q;
      ack_d   = ack_q;
      soft_d  = soft_q;

      unique case (state_q)
         ASSERT: begin
            if (rst_ok) begin
               cnt_d   = EXTEND_LOAD;
               idx_d   = '0;
               mask_d  = '1;
               soft_d  = 1'b0;
               state_d = HOLD;
            end
         end

         HOLD, RELEASE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Every index is walked even when unmasked, so soft timing is fixed.
               for (int k = 0; k < NUM_DOMAINS; k++) begin
                  if (idx_q == IDX_W'(k) && mask_q[k]) begin
                     rst_d[k] = 1'b0;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  ack_d   = soft_q;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  cnt_d   = STAGGER_LOAD;
                  state_d = RELEASE;
               end
            end
         end

         DONE: begin
            if (!sr.soft_reset_req) begin
               ack_d = 1'b0;
            end else if (!ack_q) begin
               // A request still high after its own ack is not a new request.
               mask_d  = sr.soft_reset_mask;
               rst_d   = rst_q | sr.soft_reset_mask;
               done_d  = 1'b0;
               cnt_d   = EXTEND_LOAD;
               idx_d   = '0;
               soft_d  = 1'b1;
               state_d = HOLD;
            end
         end

         default: state_d = ASSERT;
      endcase
   end

   assign sr.reset_sync     = rst_q;
   assign sr.reset_done     = done_q;
   assign sr.soft_reset_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   reset_sequencer_if #(.NUM_DOMAINS(4)) if_a ();
   reset_sequencer_if #(.NUM_DOMAINS(1)) if_b ();
   reset_sequencer_if #(.NUM_DOMAINS(3)) if_c ();

   reset_sequencer #(.NUM_DOMAINS(4), .SYNC_STAGES(2), .NUM_EXTEND_CYCLES(4), .STAGGER_CYCLES(2)) dut_a (
      .sync_clk (clk), .reset_async_n (rst_n), .sr (if_a.slave));
   reset_sequencer #(.NUM_DOMAINS(1), .SYNC_STAGES(2), .NUM_EXTEND_CYCLES(1), .STAGGER_CYCLES(0)) dut_b (
      .sync_clk (clk), .reset_async_n (rst_n), .sr (if_b.slave));
   reset_sequencer #(.NUM_DOMAINS(3), .SYNC_STAGES(2), .NUM_EXTEND_CYCLES(4), .STAGGER_CYCLES(0)) dut_c (
      .sync_clk (clk), .reset_async_n (rst_n), .sr (if_c.slave));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Walk power-on edges 1..last_edge. Release edges: A 7,10,13,16; B 4; C 7,8,9.
   task automatic power_on_walk(input int last_edge);
      logic [3:0] ea;
      logic [0:0] eb;
      logic [2:0] ec;
      for (int e = 1; e <= last_edge; e++) begin
         tick();
         ea = {e < 16, e < 13, e < 10, e < 7};
         eb = (e < 4);
         ec = {e < 9, e < 8, e < 7};
         n_cmp++;
         if (if_a.reset_sync !== ea) begin
            n_bad++; $display("FAIL power_on_a_sync edge %0d: got %b want %b", e, if_a.reset_sync, ea);
         end
         n_cmp++;
         if (if_a.reset_done !== (e >= 16)) begin
            n_bad++; $display("FAIL power_on_a_done edge %0d: got %b want %b", e, if_a.reset_done, e >= 16);
         end
         n_cmp++;
         if (if_a.soft_reset_ack !== 1'b0) begin
            n_bad++; $display("FAIL power_on_a_ack edge %0d: got %b want 0", e, if_a.soft_reset_ack);
         end
         n_cmp++;
         if ({if_b.reset_sync, if_b.reset_done} !== {eb, e >= 4}) begin
            n_bad++; $display("FAIL power_on_b edge %0d: got sync %b done %b want %b %b",
                              e, if_b.reset_sync, if_b.reset_done, eb, e >= 4);
         end
         n_cmp++;
         if ({if_c.reset_sync, if_c.reset_done} !== {ec, e >= 9}) begin
            n_bad++; $display("FAIL power_on_c edge %0d: got sync %b done %b want %b %b",
                              e, if_c.reset_sync, if_c.reset_done, ec, e >= 9);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== 6'b1111_0_0) begin
         n_bad++; $display("FAIL reset_a: got %b want 111100",
                           {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack});
      end
      n_cmp++;
      if ({if_b.reset_sync, if_b.reset_done, if_c.reset_sync, if_c.reset_done} !== 6'b1_0_111_0) begin
         n_bad++; $display("FAIL reset_bc: got %b want 101110",
                           {if_b.reset_sync, if_b.reset_done, if_c.reset_sync, if_c.reset_done});
      end
   endtask

   task automatic test_power_on();
      rst_n = 1'b1;
      power_on_walk(20);
   endtask

   task automatic test_soft_mask();
      logic [3:0] es;
      if_a.soft_reset_req  = 1'b1;
      if_a.soft_reset_mask = 4'b0101;
      for (int j = 0; j <= 13; j++) begin
         tick();
         es = {1'b0, j < 10, 1'b0, j < 4};
         n_cmp++;
         if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== {es, j >= 13, j >= 13}) begin
            n_bad++; $display("FAIL soft_mask T+%0d: got %b want %b", j,
                              {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack}, {es, j >= 13, j >= 13});
         end
      end
      // Request held high after ack: no second sequence.
      repeat (4) begin
         tick();
         n_cmp++;
         if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== 6'b0000_1_1) begin
            n_bad++; $display("FAIL soft_held: got %b want 000011",
                              {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack});
         end
      end
      if_a.soft_reset_req = 1'b0;
      tick();
      n_cmp++;
      if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== 6'b0000_1_0) begin
         n_bad++; $display("FAIL soft_ack_fall: got %b want 000010",
                           {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack});
      end
   endtask

   task automatic test_req_ignored();
      if_a.soft_reset_req  = 1'b1;
      if_a.soft_reset_mask = 4'b0001;
      tick();
      n_cmp++;
      if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== 6'b0001_0_0) begin
         n_bad++; $display("FAIL ignore_accept: got %b want 000100",
                           {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack});
      end
      if_a.soft_reset_req = 1'b0;
      for (int j = 1; j <= 17; j++) begin
         tick();
         n_cmp++;
         if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !==
             {3'b000, j < 4, j >= 13, j == 13}) begin
            n_bad++; $display("FAIL ignore T+%0d: got %b want %b", j,
                              {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack},
                              {3'b000, j < 4, j >= 13, j == 13});
         end
         // A request pulse during HOLD/RELEASE that must be dropped, not queued.
         if (j == 3) begin
            if_a.soft_reset_req  = 1'b1;
            if_a.soft_reset_mask = 4'b1000;
         end
         if (j == 6) if_a.soft_reset_req = 1'b0;
      end
   endtask

   task automatic test_zero_mask();
      if_a.soft_reset_req  = 1'b1;
      if_a.soft_reset_mask = 4'b0000;
      for (int j = 0; j <= 13; j++) begin
         tick();
         n_cmp++;
         if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== {4'b0000, j >= 13, j >= 13}) begin
            n_bad++; $display("FAIL zero_mask T+%0d: got %b want %b", j,
                              {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack},
                              {4'b0000, j >= 13, j >= 13});
         end
      end
      // Request left high so the ack is still up for the next scenario.
   endtask

   task automatic test_async_with_ack();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== 6'b1111_0_0) begin
         n_bad++; $display("FAIL async_ack_a: got %b want 111100",
                           {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack});
      end
      n_cmp++;
      if ({if_b.reset_sync, if_b.reset_done, if_c.reset_sync, if_c.reset_done} !== 6'b1_0_111_0) begin
         n_bad++; $display("FAIL async_ack_bc: got %b want 101110",
                           {if_b.reset_sync, if_b.reset_done, if_c.reset_sync, if_c.reset_done});
      end
      if_a.soft_reset_req = 1'b0;
      tick();
      rst_n = 1'b1;
      power_on_walk(11);
   endtask

   task automatic test_async_mid_power_on();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack} !== 6'b1111_0_0) begin
         n_bad++; $display("FAIL async_mid_a: got %b want 111100",
                           {if_a.reset_sync, if_a.reset_done, if_a.soft_reset_ack});
      end
      n_cmp++;
      if ({if_b.reset_sync, if_b.reset_done, if_c.reset_sync, if_c.reset_done} !== 6'b1_0_111_0) begin
         n_bad++; $display("FAIL async_mid_bc: got %b want 101110",
                           {if_b.reset_sync, if_b.reset_done, if_c.reset_sync, if_c.reset_done});
      end
      tick();
      rst_n = 1'b1;
      power_on_walk(20);
   endtask

   initial begin
      if_a.soft_reset_req  = 1'b0;
      if_a.soft_reset_mask = '0;
      if_b.soft_reset_req  = 1'b0;
      if_b.soft_reset_mask = '0;
      if_c.soft_reset_req  = 1'b0;
      if_c.soft_reset_mask = '0;
      #2;
      test_reset();
      test_power_on();
      test_soft_mask();
      test_req_ignored();
      test_zero_mask();
      test_async_with_ack();
      test_async_mid_power_on();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
